br_counter_incr_rr_alloc: RTL and testbench

- Shares one wrapping increment counter among NumRequesters clients as a sequence-number / ID-range allocator.
- A round-robin arbiter grants at most one requester per cycle. The grantee receives the counter's pre-increment value as the base of its range, and the counter advances by the requested amount.
- A small FSM sequences freeze and reinit. Sits in front of tag/sequence-number consumers (reorder buffers, packet numbering).

---
 rtl/br_counter_incr_rr_alloc_if.sv | 44 ++++
 rtl/br_counter_incr_rr_alloc.sv | 192 +++++++++++++++++++
 tb/tb_br_counter_incr_rr_alloc.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/br_counter_incr_rr_alloc_if.sv
// Request/response bundle for br_counter_incr_rr_alloc.
// BR_COUNTER_INCR_RR_ALLOC_WRAP_FLAG_EN adds resp_wrapped.
interface br_counter_incr_rr_alloc_if #(
  parameter int NumRequesters = 2,
  parameter int MaxValue = 15,
  parameter int MaxIncrement = 4
);
  localparam int ValueWidth = $clog2(MaxValue + 1);
  localparam int IncrWidth = $clog2(MaxIncrement + 1);

  logic [NumRequesters-1:0] req_valid;
  logic [NumRequesters*IncrWidth-1:0] req_incr;
  logic [NumRequesters-1:0] req_ready;
  logic [NumRequesters-1:0] resp_valid;
  logic [ValueWidth-1:0] resp_base;
  logic [IncrWidth-1:0] resp_incr;
`ifdef BR_COUNTER_INCR_RR_ALLOC_WRAP_FLAG_EN
  logic resp_wrapped;

  modport master (
    output req_valid, req_incr,
    input  req_ready, resp_valid,
    input  resp_base, resp_incr, resp_wrapped
  );

  modport slave (
    input  req_valid, req_incr,
    output req_ready, resp_valid,
    output resp_base, resp_incr, resp_wrapped
  );
`else
  modport master (
    output req_valid, req_incr,
    input  req_ready, resp_valid,
    input  resp_base, resp_incr
  );

  modport slave (
    input  req_valid, req_incr,
    output req_ready, resp_valid,
    output resp_base, resp_incr
  );
`endif
endinterface

// File: rtl/br_counter_incr_rr_alloc.sv
// Round-robin shared wrapping counter handing out ID ranges.
// BR_COUNTER_INCR_RR_ALLOC_WRAP_FLAG_EN adds resp_wrapped.
module br_counter_incr_rr_alloc #(
  parameter int NumRequesters = 2,
  parameter int MaxValue = 15,
  parameter int MaxIncrement = 4,
  parameter int ResetValue = 0,
  localparam int ValueWidth = $clog2(MaxValue + 1),
  localparam int IncrWidth = $clog2(MaxIncrement + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic freeze,
  input  logic reinit,
  input  logic [ValueWidth-1:0] initial_value,
  br_counter_incr_rr_alloc_if.slave bus,
  output logic [ValueWidth-1:0] value,
  output logic busy
);
  localparam int PtrWidth = $clog2(NumRequesters);
  localparam int SumWidth = $clog2(MaxValue + MaxIncrement + 1);
  localparam logic [SumWidth-1:0] SumMax = SumWidth'(MaxValue);
  localparam logic [SumWidth-1:0] SumMod = SumWidth'(MaxValue + 1);
  localparam logic [ValueWidth-1:0] RstVal = ValueWidth'(ResetValue);

  if (NumRequesters < 2) begin : g_bad_n
    $error("NumRequesters must be >= 2");
  end
  if (MaxIncrement < 1 || MaxIncrement > MaxValue) begin : g_bad_inc
    $error("MaxIncrement must be in 1..MaxValue");
  end
  if (ResetValue > MaxValue) begin : g_bad_rst
    $error("ResetValue must be <= MaxValue");
  end

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FREEZE,
    ST_REINIT
  } state_t;

  state_t state_q;
  logic busy_q;
  logic [PtrWidth-1:0] ptr_q;
  logic [PtrWidth-1:0] gnt_idx;
  logic [PtrWidth-1:0] ptr_nxt;
  logic [NumRequesters-1:0] gnt;
  logic found;
  logic grant_en;
  logic xfer;
  logic wrapped;
  logic [IncrWidth-1:0] sel_incr;
  logic [SumWidth-1:0] sum;
  logic [ValueWidth-1:0] value_q;
  logic [ValueWidth-1:0] value_nxt;

  function automatic logic [PtrWidth-1:0] rr_idx(
    input logic [PtrWidth-1:0] p,
    input int k
  );
    int s;
    s = int'(p) + k;
    if (s >= NumRequesters) s = s - NumRequesters;
    return PtrWidth'(s);
  endfunction

  // Freeze/reinit gate grants in the very cycle they are seen.
  assign grant_en = rst_n && (state_q == ST_RUN)
                  && !freeze && !reinit;

  // Scan upward from the RR pointer; first valid client wins.
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    found = 1'b0;
    for (int k = 0; k < NumRequesters; k++) begin
      if (!found && bus.req_valid[rr_idx(ptr_q, k)]) begin
        found = 1'b1;
        gnt_idx = rr_idx(ptr_q, k);
      end
    end
    if (grant_en && found) gnt[gnt_idx] = 1'b1;
  end

  assign xfer = |gnt;
  assign bus.req_ready = gnt;
  assign ptr_nxt = rr_idx(gnt_idx, 1);
  assign sel_incr =
    bus.req_incr[int'(gnt_idx)*IncrWidth +: IncrWidth];

  // Widened add, one conditional subtract folds back into range.
  assign sum = SumWidth'(value_q) + SumWidth'(sel_incr);
  assign wrapped = sum > SumMax;
  assign value_nxt = ValueWidth'(wrapped ? sum - SumMod : sum);

  assign value = value_q;
  assign busy = busy_q;

  // Run/freeze/reinit sequencer; reinit overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      busy_q <= 1'b0;
    end else if (reinit) begin
      state_q <= ST_REINIT;
      busy_q <= 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (freeze) begin
            state_q <= ST_FREEZE;
            busy_q <= 1'b1;
          end
        end
        ST_FREEZE: begin
          if (!freeze) begin
            state_q <= ST_RUN;
            busy_q <= 1'b0;
          end
        end
        ST_REINIT: begin
          state_q <= freeze ? ST_FREEZE : ST_RUN;
          busy_q <= freeze;
        end
        default: begin
          state_q <= ST_RUN;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Counter, RR pointer and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= RstVal;
      ptr_q <= '0;
      bus.resp_valid <= '0;
      bus.resp_base <= '0;
      bus.resp_incr <= '0;
`ifdef BR_COUNTER_INCR_RR_ALLOC_WRAP_FLAG_EN
      bus.resp_wrapped <= 1'b0;
`endif
    end else begin
      bus.resp_valid <= gnt;
`ifdef BR_COUNTER_INCR_RR_ALLOC_WRAP_FLAG_EN
      bus.resp_wrapped <= xfer & wrapped;
`endif
      if (xfer) begin
        bus.resp_base <= value_q;
        bus.resp_incr <= sel_incr;
        value_q <= value_nxt;
        ptr_q <= ptr_nxt;
      end
      if (reinit) value_q <= initial_value;
    end
  end

`ifndef SYNTHESIS
  localparam logic [ValueWidth-1:0] MaxV =
    ValueWidth'(MaxValue);
  localparam logic [IncrWidth-1:0] MaxI =
    IncrWidth'(MaxIncrement);

  a_value_range: assert property (
    @(posedge clk) disable iff (!rst_n) value_q <= MaxV);
  a_onehot: assert property (
    @(posedge clk) disable iff (!rst_n)
    $onehot0(bus.req_ready));
  a_ready_valid: assert property (
    @(posedge clk) disable iff (!rst_n)
    (bus.req_ready & ~bus.req_valid) == '0);
  a_no_grant_busy: assert property (
    @(posedge clk) disable iff (!rst_n)
    state_q != ST_RUN |-> bus.req_ready == '0);
  a_init_range: assert property (
    @(posedge clk) disable iff (!rst_n)
    reinit |-> initial_value <= MaxV);

  for (genvar i = 0; i < NumRequesters; i++) begin : g_chk
    a_incr_range: assert property (
      @(posedge clk) disable iff (!rst_n)
      bus.req_valid[i] |->
        bus.req_incr[i*IncrWidth +: IncrWidth] <= MaxI);
    a_stable: assert property (
      @(posedge clk) disable iff (!rst_n)
      bus.req_valid[i] && !bus.req_ready[i] |=>
        bus.req_valid[i] &&
        $stable(bus.req_incr[i*IncrWidth +: IncrWidth]));
  end
`endif
endmodule

// File: tb/tb_br_counter_incr_rr_alloc.sv
// Scoreboard bench for br_counter_incr_rr_alloc.
// Non-power-of-2 wrap, three clients, nonzero reset value.
`timescale 1ns/1ps
module tb_br_counter_incr_rr_alloc;
  localparam int N = 3;
  localparam int MV = 9;
  localparam int MI = 4;
  localparam int RV = 2;
  localparam int VW = $clog2(MV + 1);
  localparam int IW = $clog2(MI + 1);

  typedef struct {
    int cyc;
    int cl;
    int base;
    int incr;
    bit wr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic freeze = 1'b0;
  logic reinit = 1'b0;
  logic [VW-1:0] initial_value = '0;
  logic [VW-1:0] value;
  logic busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  exp_t q[$];
  exp_t e;
  int m_val, m_mode, m_ptr, m_gi, m_k, m_c;
  int last_base, last_incr;

  br_counter_incr_rr_alloc_if #(
    .NumRequesters(N),
    .MaxValue(MV),
    .MaxIncrement(MI)
  ) bus ();

  br_counter_incr_rr_alloc #(
    .NumRequesters(N),
    .MaxValue(MV),
    .MaxIncrement(MI),
    .ResetValue(RV)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .freeze(freeze),
    .reinit(reinit),
    .initial_value(initial_value),
    .bus(bus),
    .value(value),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d",
               nm, cyc, act, exp);
    end
  endtask

  // Reference model: spec rules evaluated each cycle pre-edge.
  // m_mode: 0 run, 1 frozen, 2 reinit cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready", bus.req_ready, 0);
      chk("rst_value", value, RV);
      chk("rst_busy", busy, 0);
      m_val = RV;
      m_mode = 0;
      m_ptr = 0;
      last_base = 0;
      last_incr = 0;
      q.delete();
    end else begin
      m_gi = -1;
      if (m_mode == 0 && !freeze && !reinit) begin
        for (int k = 0; k < N; k++) begin
          m_c = (m_ptr + k) % N;
          if (m_gi < 0 && bus.req_valid[m_c]) m_gi = m_c;
        end
      end
      chk("req_ready", bus.req_ready,
          m_gi < 0 ? 0 : (1 << m_gi));
      chk("value", value, m_val);
      chk("busy", busy, m_mode != 0);
      if (m_gi >= 0) begin
        m_k = int'(bus.req_incr[m_gi*IW +: IW]);
        q.push_back('{cyc: cyc + 1, cl: m_gi, base: m_val,
                      incr: m_k, wr: (m_val + m_k > MV)});
        m_val = (m_val + m_k) % (MV + 1);
        m_ptr = (m_gi + 1) % N;
      end
      if (reinit) begin
        m_val = int'(initial_value);
        m_mode = 2;
      end else if (m_mode == 0) begin
        if (freeze) m_mode = 1;
      end else begin
        m_mode = freeze ? 1 : 0;
      end
    end
  end

  // Monitor: pops the expected response when it is due.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_resp_valid", bus.resp_valid, 0);
      chk("rst_resp_base", bus.resp_base, 0);
      chk("rst_resp_incr", bus.resp_incr, 0);
    end else if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk("resp_valid", bus.resp_valid, 1 << e.cl);
      chk("resp_base", bus.resp_base, e.base);
      chk("resp_incr", bus.resp_incr, e.incr);
`ifdef BR_COUNTER_INCR_RR_ALLOC_WRAP_FLAG_EN
      chk("resp_wrapped", bus.resp_wrapped, e.wr);
`endif
      last_base = e.base;
      last_incr = e.incr;
    end else begin
      chk("idle_valid", bus.resp_valid, 0);
      chk("hold_base", bus.resp_base, last_base);
      chk("hold_incr", bus.resp_incr, last_incr);
`ifdef BR_COUNTER_INCR_RR_ALLOC_WRAP_FLAG_EN
      chk("idle_wrapped", bus.resp_wrapped, 0);
`endif
    end
  end

  function automatic logic [N*IW-1:0] pack(input int a,
                                           input int b,
                                           input int c);
    return {IW'(c), IW'(b), IW'(a)};
  endfunction

  // Drop requests as they are accepted, bounded.
  task automatic drain(input int max_cyc);
    logic [N-1:0] acc;
    int n;
    n = 0;
    while (bus.req_valid != '0 && n < max_cyc) begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      reinit = 1'b0;
      bus.req_valid = bus.req_valid & ~acc;
      n++;
    end
    chk("drain_done", bus.req_valid, 0);
  endtask

  task automatic issue(input logic [N-1:0] v,
                       input logic [N*IW-1:0] inc);
    @(posedge clk);
    #1;
    bus.req_valid = v;
    bus.req_incr = inc;
    drain(20);
  endtask

  // Random cycle honouring hold-until-accepted.
  task automatic step(input int pv, input int pf,
                      input int pr);
    logic [N-1:0] acc;
    @(negedge clk);
    acc = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (!bus.req_valid[i] || acc[i]) begin
        bus.req_valid[i] = ($urandom_range(99) < pv);
        bus.req_incr[i*IW +: IW] = IW'($urandom_range(MI));
      end
    end
    if ($urandom_range(99) < pf) freeze = ~freeze;
    reinit = ($urandom_range(99) < pr);
    initial_value = VW'($urandom_range(MV));
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_incr = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    issue(3'b001, pack(3, 0, 0));

    @(posedge clk);
    #1;
    freeze = 1'b1;
    bus.req_valid = 3'b111;
    bus.req_incr = pack(2, 2, 2);
    repeat (3) @(posedge clk);
    #1 freeze = 1'b0;
    drain(20);

    @(posedge clk);
    #1;
    reinit = 1'b1;
    initial_value = VW'(5);
    bus.req_valid = 3'b001;
    bus.req_incr = pack(1, 0, 0);
    drain(20);

    @(posedge clk);
    #1;
    reinit = 1'b1;
    initial_value = VW'(8);
    @(posedge clk);
    #1 reinit = 1'b0;
    issue(3'b010, pack(0, 4, 0));
    issue(3'b010, pack(0, 0, 0));
    issue(3'b111, pack(4, 3, 1));

    repeat (800) step(70, 8, 4);
    freeze = 1'b0;
    reinit = 1'b0;
    drain(20);

    @(posedge clk);
    #1;
    bus.req_valid = 3'b100;
    bus.req_incr = pack(0, 0, 3);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    repeat (400) step(60, 6, 3);
    freeze = 1'b0;
    reinit = 1'b0;
    drain(20);
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
